// File: rtl/note_player_poly_pkg.sv
// rtl/note_player_poly_pkg.sv - shared constants, mixer state encoding and helpers for note_player_poly
package note_player_poly_pkg;

  localparam int NOTE_REST = 0;

  localparam int DEF_VOICES    = 3;
  localparam int DEF_NOTE_W    = 6;
  localparam int DEF_DUR_W     = 6;
  localparam int DEF_SAMPLE_W  = 16;
  localparam int DEF_MIX_SHIFT = 1;

  // Phase accumulator width and native width of the sine table
  localparam int PHASE_W = 16;
  localparam int WAVE_W  = 16;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_WAIT = 2'd1,
    M_OUT  = 2'd2
  } mixer_state_t;

  // Ceiling log2; clog2(1) = 0 so a single voice needs no sum headroom
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res++;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/note_player_poly_if.sv
// rtl/note_player_poly_if.sv - sequencer/codec side bus of the polyphonic note player
interface note_player_poly_if
  import note_player_poly_pkg::*;
#(
  parameter int VOICES   = DEF_VOICES,
  parameter int NOTE_W   = DEF_NOTE_W,
  parameter int DUR_W    = DEF_DUR_W,
  parameter int SAMPLE_W = DEF_SAMPLE_W
);
  logic                       play_enable;
  logic [VOICES-1:0]          load_new_note;
  logic [VOICES*NOTE_W-1:0]   note_to_load;
  logic [VOICES*DUR_W-1:0]    duration_to_load;
  logic                       beat;
  logic                       generate_next_sample;
  logic [VOICES-1:0]          done_with_note;
  logic [VOICES-1:0]          voice_active;
  logic signed [SAMPLE_W-1:0] sample_out;
  logic                       new_sample_ready;

  modport master (
    output play_enable, load_new_note, note_to_load, duration_to_load, beat, generate_next_sample,
    input  done_with_note, voice_active, sample_out, new_sample_ready
  );

  modport slave (
    input  play_enable, load_new_note, note_to_load, duration_to_load, beat, generate_next_sample,
    output done_with_note, voice_active, sample_out, new_sample_ready
  );
endinterface

// File: rtl/dff.sv
// rtl/dff.sv - generic register cell with asynchronous active-high clear
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Plain state register, cleared to zero on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end
endmodule

// File: rtl/note_player_poly_voice.sv
// rtl/note_player_poly_voice.sv - one voice: note/duration registers, frequency lookup and sine reader
module frequency_rom
  import note_player_poly_pkg::*;
#(
  parameter int NOTE_W = DEF_NOTE_W
) (
  input  logic [NOTE_W-1:0]  note,
  output logic [PHASE_W-1:0] step
);
  // Linear map: each note index advances the phase by 1/256 of a cycle per sample
  assign step = PHASE_W'(note) << 8;
endmodule

module sine_reader
  import note_player_poly_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     generate_next,
  input  logic [PHASE_W-1:0]       step,
  output logic signed [WAVE_W-1:0] sample,
  output logic                     sample_ready
);
  logic [PHASE_W-1:0]       phase_q;
  logic [5:0]               idx_q;
  logic                     req_q;
  logic [4:0]               qpos;
  logic signed [WAVE_W-1:0] qval;
  logic signed [WAVE_W-1:0] wave;

  // Stage 1: capture the table index of the current phase, then advance the phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      idx_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      req_q <= generate_next;
      if (generate_next) begin
        idx_q   <= phase_q[PHASE_W-1 -: 6];
        phase_q <= phase_q + step;
      end
    end
  end

  // Fold the 64-step cycle onto a 17-entry quarter wave; the negative half mirrors as one's complement
  always_comb begin
    qpos = idx_q[4] ? (5'd16 - {1'b0, idx_q[3:0]}) : {1'b0, idx_q[3:0]};
    case (qpos)
      5'd0:    qval = 16'sd0;
      5'd1:    qval = 16'sd3212;
      5'd2:    qval = 16'sd6393;
      5'd3:    qval = 16'sd9512;
      5'd4:    qval = 16'sd12539;
      5'd5:    qval = 16'sd15446;
      5'd6:    qval = 16'sd18204;
      5'd7:    qval = 16'sd20787;
      5'd8:    qval = 16'sd23170;
      5'd9:    qval = 16'sd25329;
      5'd10:   qval = 16'sd27245;
      5'd11:   qval = 16'sd28898;
      5'd12:   qval = 16'sd30273;
      5'd13:   qval = 16'sd31356;
      5'd14:   qval = 16'sd32137;
      5'd15:   qval = 16'sd32609;
      default: qval = 16'sd32767;
    endcase
    wave = idx_q[5] ? ~qval : qval;
  end

  // Stage 2: register the looked-up sample together with its ready flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample       <= '0;
      sample_ready <= 1'b0;
    end else begin
      sample_ready <= req_q;
      if (req_q) sample <= wave;
    end
  end
endmodule

module note_voice
  import note_player_poly_pkg::*;
#(
  parameter int NOTE_W   = DEF_NOTE_W,
  parameter int DUR_W    = DEF_DUR_W,
  parameter int SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       play_enable,
  input  logic                       load,
  input  logic [NOTE_W-1:0]          note_in,
  input  logic [DUR_W-1:0]           dur_in,
  input  logic                       beat,
  input  logic                       generate_next,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       sample_ready,
  output logic                       done,
  output logic                       active
);
  logic [NOTE_W-1:0]          note_q;
  logic [DUR_W-1:0]           dur_q;
  logic                       done_q;
  logic [PHASE_W-1:0]         step;
  logic signed [WAVE_W-1:0]   wave;
  logic signed [SAMPLE_W-1:0] scaled;

  // Load wins over a same-cycle beat; the last counted beat raises done for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_q <= '0;
      dur_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        note_q <= note_in;
        dur_q  <= dur_in;
      end else if (play_enable && beat && dur_q != '0) begin
        dur_q <= dur_q - DUR_W'(1);
        if (dur_q == DUR_W'(1)) done_q <= 1'b1;
      end
    end
  end

  frequency_rom #(.NOTE_W(NOTE_W)) u_rom (
    .note (note_q),
    .step (step)
  );

  sine_reader u_sine (
    .clk           (clk),
    .rst           (rst),
    .generate_next (generate_next),
    .step          (step),
    .sample        (wave),
    .sample_ready  (sample_ready)
  );

  // Match the table width to the voice sample width
  if (SAMPLE_W == WAVE_W) begin : g_same
    assign scaled = wave;
  end else if (SAMPLE_W > WAVE_W) begin : g_widen
    assign scaled = {wave, {(SAMPLE_W-WAVE_W){1'b0}}};
  end else begin : g_narrow
    assign scaled = wave[WAVE_W-1 -: SAMPLE_W];
  end

  assign active = (dur_q != '0);
  assign done   = done_q;
  assign sample = (note_q == NOTE_W'(NOTE_REST) || !active) ? '0 : scaled;
endmodule

// File: rtl/note_player_poly.sv
// rtl/note_player_poly.sv - polyphonic note player: voice array plus sum/shift/saturate mixer
module note_player_poly
  import note_player_poly_pkg::*;
#(
  parameter int VOICES    = DEF_VOICES,
  parameter int NOTE_W    = DEF_NOTE_W,
  parameter int DUR_W     = DEF_DUR_W,
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int MIX_SHIFT = DEF_MIX_SHIFT
) (
  input logic              clk,
  input logic              reset,
  note_player_poly_if.slave bus
);
  localparam int SUM_W = SAMPLE_W + clog2(VOICES);
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'({1'b0, {(SAMPLE_W-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  mixer_state_t               state;
  mixer_state_t               next_state;
  logic [1:0]                 state_bits;
  logic                       start_mix;
  logic                       load_out;
  logic                       all_ready;
  logic [VOICES-1:0]          voice_ready;
  logic [VOICES-1:0]          rdy_latch;
  logic [VOICES-1:0]          done_v;
  logic [VOICES-1:0]          active_v;
  logic signed [SAMPLE_W-1:0] voice_sample [VOICES];
  logic signed [SAMPLE_W-1:0] lat_sample   [VOICES];
  logic signed [SUM_W-1:0]    sum;
  logic signed [SUM_W-1:0]    shifted;
  logic signed [SAMPLE_W-1:0] mixed;
  logic signed [SAMPLE_W-1:0] sample_q;
  logic                       ready_q;

  for (genvar i = 0; i < VOICES; i++) begin : g_voice
    note_voice #(
      .NOTE_W   (NOTE_W),
      .DUR_W    (DUR_W),
      .SAMPLE_W (SAMPLE_W)
    ) u_voice (
      .clk           (clk),
      .rst           (reset),
      .play_enable   (bus.play_enable),
      .load          (bus.load_new_note[i]),
      .note_in       (bus.note_to_load[i*NOTE_W +: NOTE_W]),
      .dur_in        (bus.duration_to_load[i*DUR_W +: DUR_W]),
      .beat          (bus.beat),
      .generate_next (start_mix),
      .sample        (voice_sample[i]),
      .sample_ready  (voice_ready[i]),
      .done          (done_v[i]),
      .active        (active_v[i])
    );
  end

  dff #(.W(2)) u_state (
    .clk (clk),
    .rst (reset),
    .d   (next_state),
    .q   (state_bits)
  );
  assign state = mixer_state_t'(state_bits);

  assign all_ready = &(rdy_latch | voice_ready);

  // Next-state: one request per mix, wait for every voice, then one output cycle
  always_comb begin
    next_state = state;
    case (state)
      M_IDLE:  if (start_mix) next_state = M_WAIT;
      M_WAIT:  if (all_ready) next_state = M_OUT;
      M_OUT:   next_state = M_IDLE;
      default: next_state = M_IDLE;
    endcase
  end

  // Outputs: request strobe only from idle while playing, output load in M_OUT
  always_comb begin
    start_mix = 1'b0;
    load_out  = 1'b0;
    case (state)
      M_IDLE:  start_mix = bus.generate_next_sample & bus.play_enable;
      M_OUT:   load_out  = 1'b1;
      default: ;
    endcase
  end

  // Collect each voice's sample as it arrives; a new request clears the set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_latch <= '0;
      for (int v = 0; v < VOICES; v++) lat_sample[v] <= '0;
    end else if (start_mix) begin
      rdy_latch <= '0;
    end else if (state == M_WAIT) begin
      for (int v = 0; v < VOICES; v++) begin
        if (voice_ready[v]) begin
          rdy_latch[v]  <= 1'b1;
          lat_sample[v] <= voice_sample[v];
        end
      end
    end
  end

  // Sign-extended sum, arithmetic scale, clamp to the output range
  always_comb begin
    sum = '0;
    for (int v = 0; v < VOICES; v++) sum = sum + SUM_W'(lat_sample[v]);
    shifted = sum >>> MIX_SHIFT;
    if (shifted > SAT_MAX)      mixed = SAT_MAX[SAMPLE_W-1:0];
    else if (shifted < SAT_MIN) mixed = SAT_MIN[SAMPLE_W-1:0];
    else                        mixed = shifted[SAMPLE_W-1:0];
  end

  // Output sample holds between mixes; ready pulses for the load cycle only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      ready_q <= load_out;
      if (load_out) sample_q <= mixed;
    end
  end

  assign bus.done_with_note   = done_v;
  assign bus.voice_active     = active_v;
  assign bus.sample_out       = sample_q;
  assign bus.new_sample_ready = ready_q;
endmodule

// File: tb/tb_note_player_poly.sv
// tb/tb_note_player_poly.sv - directed self-checking bench for note_player_poly
module tb_note_player_poly;

  logic clk;
  logic reset;
  int   n_asserts;
  int   n_fails;

  note_player_poly_if #(.VOICES(3), .NOTE_W(6), .DUR_W(6), .SAMPLE_W(16)) ia ();
  note_player_poly_if #(.VOICES(3), .NOTE_W(6), .DUR_W(6), .SAMPLE_W(16)) ib ();

  note_player_poly #(.VOICES(3), .NOTE_W(6), .DUR_W(6), .SAMPLE_W(16), .MIX_SHIFT(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ia)
  );

  note_player_poly #(.VOICES(3), .NOTE_W(6), .DUR_W(6), .SAMPLE_W(16), .MIX_SHIFT(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic req_a(input bit extra, output logic signed [15:0] s, output int pulses);
    ia.generate_next_sample = 1'b1;
    tick();
    ia.generate_next_sample = 1'b0;
    s = 'x;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (extra && i == 0) ia.generate_next_sample = 1'b1;
      tick();
      ia.generate_next_sample = 1'b0;
      if (ia.new_sample_ready === 1'b1) begin
        pulses++;
        s = ia.sample_out;
      end
    end
  endtask

  task automatic req_b(output logic signed [15:0] s, output int pulses);
    ib.generate_next_sample = 1'b1;
    tick();
    ib.generate_next_sample = 1'b0;
    s = 'x;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ib.new_sample_ready === 1'b1) begin
        pulses++;
        s = ib.sample_out;
      end
    end
  endtask

  task automatic beat_a();
    ia.beat = 1'b1;
    tick();
    ia.beat = 1'b0;
  endtask

  initial begin
    logic signed [15:0] s;
    int                 p;
    logic [2:0]         acc;
    int                 np;

    n_asserts = 0;
    n_fails   = 0;
    reset = 1'b1;
    ia.play_enable = 1'b1; ia.load_new_note = '0; ia.note_to_load = '0;
    ia.duration_to_load = '0; ia.beat = 1'b0; ia.generate_next_sample = 1'b0;
    ib.play_enable = 1'b1; ib.load_new_note = '0; ib.note_to_load = '0;
    ib.duration_to_load = '0; ib.beat = 1'b0; ib.generate_next_sample = 1'b0;
    repeat (2) tick();
    chk("rst_sample_a", ia.sample_out, 0);
    chk("rst_ready_a", ia.new_sample_ready, 0);
    chk("rst_active_a", ia.voice_active, 0);
    chk("rst_done_a", ia.done_with_note, 0);
    chk("rst_sample_b", ib.sample_out, 0);
    reset = 1'b0;
    tick();

    // Unscaled mixer: three voices at the same phase saturate positive
    ib.load_new_note = 3'b111;
    ib.note_to_load = {6'd16, 6'd16, 6'd16};
    ib.duration_to_load = {6'd63, 6'd63, 6'd63};
    tick();
    ib.load_new_note = '0;
    for (int n = 1; n <= 5; n++) begin
      req_b(s, p);
      if (n == 1) chk("b_req1_zero", s, 0);
      if (n == 1) chk("b_req1_pulses", p, 1);
      if (n == 3) chk("b_req3_sat", s, 32767);
      if (n == 5) chk("b_req5_sat", s, 32767);
    end

    // Countdown: voice0 dur 3, voice1 dur 1
    ia.load_new_note = 3'b011;
    ia.note_to_load = {6'd0, 6'd0, 6'd10};
    ia.duration_to_load = {6'd0, 6'd1, 6'd3};
    tick();
    ia.load_new_note = '0;
    chk("load_active", ia.voice_active, 3'b011);
    beat_a();
    chk("beat1_done", ia.done_with_note, 3'b010);
    chk("beat1_active", ia.voice_active, 3'b001);
    tick();
    chk("beat1_done_clear", ia.done_with_note, 3'b000);
    beat_a();
    chk("beat2_done", ia.done_with_note, 3'b000);
    beat_a();
    chk("beat3_done", ia.done_with_note, 3'b001);
    chk("beat3_active", ia.voice_active, 3'b000);
    tick();
    chk("beat3_done_clear", ia.done_with_note, 3'b000);

    // Load and beat together on voice2: the beat is lost
    ia.load_new_note = 3'b100;
    ia.note_to_load = {6'd5, 6'd0, 6'd0};
    ia.duration_to_load = {6'd5, 6'd0, 6'd0};
    ia.beat = 1'b1;
    tick();
    ia.load_new_note = '0;
    ia.beat = 1'b0;
    chk("ldbeat_active", ia.voice_active, 3'b100);
    acc = '0;
    for (int k = 0; k < 4; k++) begin
      beat_a();
      acc = acc | ia.done_with_note;
    end
    chk("ldbeat_no_early_done", acc, 3'b000);
    chk("ldbeat_still_active", ia.voice_active, 3'b100);
    beat_a();
    chk("ldbeat_done5", ia.done_with_note, 3'b100);

    // play_enable low freezes countdown and requests
    ia.load_new_note = 3'b001;
    ia.note_to_load = '0;
    ia.duration_to_load = {6'd0, 6'd0, 6'd2};
    tick();
    ia.load_new_note = '0;
    ia.play_enable = 1'b0;
    acc = '0;
    for (int k = 0; k < 3; k++) begin
      beat_a();
      acc = acc | ia.done_with_note;
    end
    req_a(1'b0, s, p);
    chk("frz_active", ia.voice_active, 3'b001);
    chk("frz_no_done", acc, 3'b000);
    chk("frz_no_ready", p, 0);
    ia.play_enable = 1'b1;
    beat_a();
    chk("resume_active", ia.voice_active, 3'b001);
    chk("resume_no_done", ia.done_with_note, 3'b000);
    beat_a();
    chk("resume_done", ia.done_with_note, 3'b001);

    // All voices rest; an extra request during M_WAIT must be ignored
    ia.load_new_note = 3'b111;
    ia.note_to_load = '0;
    ia.duration_to_load = {6'd0, 6'd0, 6'd5};
    tick();
    ia.load_new_note = '0;
    for (int n = 0; n < 4; n++) begin
      req_a(1'b1, s, p);
      chk("rest_pulses", p, 1);
      chk("rest_sample", s, 0);
    end

    // Two voices at the same phase, one rest, MIX_SHIFT=1
    ia.load_new_note = 3'b111;
    ia.note_to_load = {6'd0, 6'd16, 6'd16};
    ia.duration_to_load = {6'd63, 6'd63, 6'd63};
    tick();
    ia.load_new_note = '0;
    for (int n = 1; n <= 13; n++) begin
      req_a(1'b0, s, p);
      if (n == 1)  chk("a_req1", s, 0);
      if (n == 2)  chk("a_req2", s, 12539);
      if (n == 3)  chk("a_req3", s, 23170);
      if (n == 5)  chk("a_req5_pos_peak", s, 32767);
      if (n == 13) chk("a_req13_neg_peak", s, -32768);
      if (n == 13) chk("a_req13_pulses", p, 1);
    end

    // Reset in the middle of a mix
    ia.generate_next_sample = 1'b1;
    tick();
    ia.generate_next_sample = 1'b0;
    tick();
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_sample", ia.sample_out, 0);
    chk("midrst_ready", ia.new_sample_ready, 0);
    chk("midrst_active", ia.voice_active, 3'b000);
    chk("midrst_done", ia.done_with_note, 3'b000);
    tick();
    reset = 1'b0;
    np = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ia.new_sample_ready !== 1'b0) np++;
    end
    chk("midrst_no_pulse", np, 0);
    chk("midrst_sample_held", ia.sample_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/note_player_poly.md
Name: note_player_poly

Overview:
Polyphonic, parametrised successor to the single-voice note player. It plays VOICES independent notes at once. Each voice has its own note/duration registers, beat countdown, frequency lookup and sine generator. A mixer FSM waits until every voice has delivered its sample for a codec request, then sums the samples, scales and saturates the result, and presents one signed sample with a single-cycle ready pulse. It sits between the song reader / chord sequencer and the codec interface.

Parameters:
VOICES, 3, number of simultaneous voices (1..8)
NOTE_W, 6, note index width (frequency_rom address)
DUR_W, 6, duration width in 1/48 s beats
SAMPLE_W, 16, signed sample width, for both voice and mixed output
MIX_SHIFT, 1, arithmetic right shift applied to the voice sum before saturation

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
play_enable  in  1  high = play; gates countdown and sample requests
load_new_note  in  VOICES  per-voice load strobe
note_to_load  in  VOICES*NOTE_W  packed notes; voice i at [i*NOTE_W +: NOTE_W]
duration_to_load  in  VOICES*DUR_W  packed durations, same packing
beat  in  1  1/48 s beat pulse
generate_next_sample  in  1  codec sample request pulse
done_with_note  out  VOICES  per-voice one-cycle done pulse
voice_active  out  VOICES  voice has remaining duration > 0
sample_out  out  SAMPLE_W  mixed signed sample, held between updates
new_sample_ready  out  1  one-cycle pulse; sample_out valid that cycle

Behaviour:
- Reset (async): all note and duration registers 0; done_with_note=0; voice_active=0; sample_out=0; new_sample_ready=0; mixer in M_IDLE; ready latches cleared.
- Per voice i, registered, one cycle of latency:
  - load_new_note[i] loads note and duration. Load has priority over a beat in the same cycle; the beat is lost for that voice.
  - Else if play_enable & beat & dur!=0: dur decrements. If dur was 1, done_with_note[i] pulses high for exactly the next cycle.
  - Loading duration 0: voice stays inactive, no done pulse.
  - voice_active[i] = (dur!=0).
  - A load while active restarts the voice with no done pulse.
- Rest: note 0, or an inactive voice, contributes 0 to the mix. Its duration still counts down.
- Mixer FSM:
  - M_IDLE: on generate_next_sample & play_enable, strobe generate_next to every voice's sine_reader in the same cycle, clear the ready latches, go to M_WAIT.
  - M_WAIT: latch each voice's sample_ready and sample value. When all VOICES latches are set, go to M_OUT. generate_next_sample is ignored in M_WAIT.
  - M_OUT (one cycle): sum the sign-extended samples at width SAMPLE_W+clog2(VOICES), apply arithmetic shift right by MIX_SHIFT, saturate to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1], register into sample_out, pulse new_sample_ready, return to M_IDLE.
  - Mix latency is max(voice reader latency) + 2 cycles after the request.
- play_enable falling in M_WAIT: the current mix completes normally. No new requests start while it is low.
- Every voice samples the same beat and generate_next_sample. The voice phase accumulators run continuously, including for rests.
- Reset mid-mix: the mix is aborted, no ready pulse, sample_out=0.

Decomposition:
- Shared package:
  - NOTE_REST=0
  - mixer state encoding M_IDLE/M_WAIT/M_OUT
  - clog2 function
  - default widths
- Sub-module note_voice: one instance per voice.
  - Contains the note/duration/done registers, frequency_rom and sine_reader.
  - Outputs sample, sample_ready, done and active.
- Top level: generate loop over note_voice, plus mixer FSM, sum/shift/saturate, and output registers. Uses the existing dff cells for state.

Test Plan:
- Reset while voices active and in M_WAIT -> all outputs 0 the same cycle; after release, no new_sample_ready until a fresh request.
- Voice0 load note 10 dur 3, voice1 load dur 1, 3 beats with play_enable=1 -> done_with_note=2'b010 one cycle after beat 1; 3'b001 one cycle after beat 3; voice_active tracks the counts.
- Load and beat on the same cycle for voice 2, dur 5 -> dur reads 5 (not 4); the done pulse comes 5 beats later.
- All voices rest (note 0), 4 requests -> 4 single-cycle new_sample_ready pulses, sample_out=0 each time; requests during M_WAIT produce no extra pulses.
- Saturation with VOICES=3, MIX_SHIFT=0, all voices at +32767 -> sample_out=32767. With MIX_SHIFT=1, voices at -32768,-32768,0 -> -32768.
- play_enable=0 with beats and requests -> durations frozen, no done pulses, no new_sample_ready. Re-enable -> countdown resumes from the held value.
